// File: rtl/vga_pkg.sv
// Shared video constants and the memory-controller state type, also used by the display stage.
package vga_pkg;
  localparam int SCREEN_LENGTH   = 320;
  localparam int SCREEN_WIDTH    = 200;
  localparam int VMEM_ADDR_WIDTH = 20;
  localparam int PIXEL_WIDTH     = 12;
  localparam int MAX_ADDR        = SCREEN_LENGTH * SCREEN_WIDTH - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } vmem_state_t;
endpackage

// File: rtl/vmem_dpram.sv
// Simple dual-port frame buffer: A is read-only, B is read/write; both read-first, 1-cycle latency.
module vmem_dpram #(
  parameter int DEPTH = 64000,
  parameter int IW    = 16,
  parameter int PW    = 12
) (
  input  logic          pclk,
  input  logic [IW-1:0] a_addr,
  output logic [PW-1:0] a_data,
  input  logic          b_we,
  input  logic [IW-1:0] b_addr,
  input  logic [PW-1:0] b_wdata,
  output logic [PW-1:0] b_rdata
);
  logic [PW-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    a_data  <= mem[a_addr];
    b_rdata <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_wdata;
  end
endmodule

// File: rtl/vga_vmem_ctrl.sv
// Frame-buffer controller: display read port, CPU valid/ready port and a one-pixel-per-cycle fill engine.
module vga_vmem_ctrl #(
  parameter int SCREEN_LENGTH   = vga_pkg::SCREEN_LENGTH,
  parameter int SCREEN_WIDTH    = vga_pkg::SCREEN_WIDTH,
  parameter int VMEM_ADDR_WIDTH = vga_pkg::VMEM_ADDR_WIDTH,
  parameter int PIXEL_WIDTH     = vga_pkg::PIXEL_WIDTH
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic [VMEM_ADDR_WIDTH-1:0] disp_addr,
  output logic [PIXEL_WIDTH-1:0]     disp_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [VMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [PIXEL_WIDTH-1:0]     req_wdata,
  output logic                       rsp_valid,
  output logic [PIXEL_WIDTH-1:0]     rsp_rdata,
  output logic                       rsp_err,
  input  logic                       fill_start,
  input  logic [PIXEL_WIDTH-1:0]     fill_color,
  output logic                       fill_busy,
  output logic                       fill_done
);
  localparam int AW    = VMEM_ADDR_WIDTH;
  localparam int PW    = PIXEL_WIDTH;
  localparam int DEPTH = SCREEN_LENGTH * SCREEN_WIDTH;
  localparam int IW    = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_ADDR_V = AW'(DEPTH - 1);

  vga_pkg::vmem_state_t state, state_d;
  logic [AW-1:0] fill_addr, fill_addr_d;
  logic [PW-1:0] fill_col, fill_col_d;
  logic          req_fire, req_in_range, fill_last;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [PW-1:0] b_wdata, a_q, b_q;
  logic          disp_ok, rd_ok;

  assign req_ready    = (state == vga_pkg::ST_IDLE);
  assign fill_busy    = (state == vga_pkg::ST_FILL);
  assign req_fire     = req_valid & req_ready;
  assign req_in_range = (req_addr <= MAX_ADDR_V);
  assign fill_last    = fill_busy && (fill_addr == MAX_ADDR_V);

  always_comb begin
    state_d     = state;
    fill_addr_d = fill_addr;
    fill_col_d  = fill_col;
    case (state)
      vga_pkg::ST_IDLE: begin
        if (fill_start) begin
          state_d     = vga_pkg::ST_FILL;
          fill_addr_d = '0;
          fill_col_d  = fill_color;
        end
      end
      vga_pkg::ST_FILL: begin
        if (fill_last) begin
          state_d     = vga_pkg::ST_IDLE;
          fill_addr_d = '0;
        end else begin
          fill_addr_d = fill_addr + AW'(1);
        end
      end
      default: state_d = vga_pkg::ST_IDLE;
    endcase
  end

  // Fill owns port B while busy; a reset edge must not commit the pending fill pixel.
  assign b_we    = !reset && (fill_busy || (req_fire && req_we && req_in_range));
  assign b_addr  = fill_busy ? fill_addr : req_addr;
  assign b_wdata = fill_busy ? fill_col : req_wdata;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= vga_pkg::ST_IDLE;
      fill_addr <= '0;
      fill_col  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      fill_done <= 1'b0;
      disp_ok   <= 1'b0;
    end else begin
      state     <= state_d;
      fill_addr <= fill_addr_d;
      fill_col  <= fill_col_d;
      rsp_valid <= req_fire;
      rsp_err   <= req_fire && !req_in_range;
      rd_ok     <= req_fire && !req_we && req_in_range;
      fill_done <= fill_last;
      disp_ok   <= (disp_addr <= MAX_ADDR_V);
    end
  end

  vmem_dpram #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) u_ram (
    .pclk    (pclk),
    .a_addr  (disp_addr[IW-1:0]),
    .a_data  (a_q),
    .b_we    (b_we),
    .b_addr  (b_addr[IW-1:0]),
    .b_wdata (b_wdata),
    .b_rdata (b_q)
  );

  // RAM outputs are masked by registered range flags so out-of-range reads return 0.
  assign disp_data = disp_ok ? a_q : '0;
  assign rsp_rdata = rd_ok ? b_q : '0;
endmodule

// File: tb/tb_vga_vmem_ctrl.sv
// Directed bench for vga_vmem_ctrl in an 8x4 configuration (MAX_ADDR = 31).
module tb_vga_vmem_ctrl;
  localparam int AW = 20;
  localparam int PW = 12;

  logic          pclk = 1'b0;
  logic          reset;
  logic [AW-1:0] disp_addr;
  logic [PW-1:0] disp_data;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [PW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [PW-1:0] rsp_rdata;
  logic          fill_start, fill_busy, fill_done;
  logic [PW-1:0] fill_color;

  int vectors = 0;
  int errors  = 0;

  always #5 pclk = ~pclk;

  vga_vmem_ctrl #(
    .SCREEN_LENGTH(8), .SCREEN_WIDTH(4), .VMEM_ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)
  ) dut (
    .pclk(pclk), .reset(reset),
    .disp_addr(disp_addr), .disp_data(disp_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic we, input logic [AW-1:0] addr, input logic [PW-1:0] wd);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, ready_bad, waited;
    reset = 1'b1; disp_addr = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; fill_start = 1'b0; fill_color = '0;

    // Reset
    tick(); tick(); tick();
    chk("rst_disp_data", 32'(disp_data), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_fill_busy", 32'(fill_busy), 32'h0);
    chk("rst_fill_done", 32'(fill_done), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    reset = 1'b0;
    tick();

    // Write then read
    cpu(1'b1, 20'd5, 12'hABC);
    chk("wr5_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr5_rsp_err",   32'(rsp_err),   32'h0);
    chk("wr5_rsp_rdata", 32'(rsp_rdata), 32'h0);
    cpu(1'b0, 20'd5, 12'h000);
    chk("rd5_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd5_rsp_rdata", 32'(rsp_rdata), 32'hABC);
    chk("rd5_rsp_err",   32'(rsp_err),   32'h0);
    disp_addr = 20'd5;
    tick();
    chk("disp5_data",    32'(disp_data), 32'hABC);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Out of range: address 32 must not alias onto address 0
    cpu(1'b1, 20'd0, 12'h111);
    cpu(1'b1, 20'd32, 12'hFFF);
    chk("wr32_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr32_rsp_err",   32'(rsp_err),   32'h1);
    cpu(1'b0, 20'd0, 12'h000);
    chk("rd0_unchanged",  32'(rsp_rdata), 32'h111);
    cpu(1'b0, 20'd40, 12'h000);
    chk("rd40_rsp_err",   32'(rsp_err),   32'h1);
    chk("rd40_rsp_rdata", 32'(rsp_rdata), 32'h0);
    disp_addr = 20'd32;
    tick();
    chk("disp32_data",    32'(disp_data), 32'h0);

    // Fill
    fill_start = 1'b1; fill_color = 12'h0F0;
    tick();
    fill_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; ready_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (fill_busy) busy_cnt++;
      if (fill_busy && req_ready) ready_bad++;
      if (fill_done) done_cnt++;
      tick();
    end
    chk("fill_busy_cycles", 32'(busy_cnt),  32'd32);
    chk("fill_done_pulses", 32'(done_cnt),  32'd1);
    chk("fill_ready_low",   32'(ready_bad), 32'd0);
    for (int a = 0; a < 32; a++) begin
      disp_addr = AW'(a);
      tick();
      chk($sformatf("fill_sweep_%0d", a), 32'(disp_data), 32'h0F0);
    end

    // Simultaneous request and fill_start; mid-fill restart ignored
    fill_start = 1'b1; fill_color = 12'hA5A;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'd3; req_wdata = 12'h123;
    tick();
    fill_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    chk("sim_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("sim_rsp_err",   32'(rsp_err),   32'h0);
    chk("sim_fill_busy", 32'(fill_busy), 32'h1);
    repeat (5) tick();
    fill_start = 1'b1; fill_color = 12'h00F;
    tick();
    fill_start = 1'b0;
    waited = 0;
    while (!fill_done && waited < 60) begin
      tick();
      waited++;
    end
    chk("sim_fill_done_seen", 32'(fill_done), 32'h1);
    tick();
    chk("sim_busy_after_done", 32'(fill_busy), 32'h0);
    cpu(1'b0, 20'd3, 12'h000);
    chk("sim_addr3_fillcol", 32'(rsp_rdata), 32'hA5A);
    for (int k = 0; k < 4; k++) begin
      disp_addr = AW'(k * 10 + 1);
      tick();
      chk($sformatf("sim_colour_kept_%0d", k * 10 + 1), 32'(disp_data), 32'hA5A);
    end

    // Reset mid-fill at fill_addr == 10
    fill_start = 1'b1; fill_color = 12'h777;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    chk("mid_busy_before", 32'(fill_busy), 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_busy_after_rst", 32'(fill_busy), 32'h0);
    chk("mid_done_after_rst", 32'(fill_done), 32'h0);
    reset = 1'b0;
    tick();
    chk("mid_done_later",  32'(fill_done), 32'h0);
    chk("mid_ready",       32'(req_ready), 32'h1);
    for (int a = 0; a < 32; a++) begin
      disp_addr = AW'(a);
      tick();
      chk($sformatf("mid_sweep_%0d", a), 32'(disp_data), (a < 10) ? 32'h777 : 32'hA5A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
